// File: rtl/sar_ctrl.sv
// rtl/sar_ctrl.sv - successive-approximation ADC sequencer (track/hold, DAC trial code, comparator)
//
// Purpose:
//   Drives an external track/hold switch, an N-bit DAC and one comparator to
//   produce one N-bit binary-search conversion per START request. Every output
//   comes straight from a flop so the block maps onto plain gates plus DFFs.
//
// Ports:
//   C       in   clock, all state updates on the rising edge
//   RN      in   asynchronous active-low reset
//   START   in   conversion request, honoured only while idle
//   ABORT   in   synchronous abort of a running conversion (wins over START)
//   CMP     in   comparator, 1 when analog input >= DAC voltage
//   SAMPLE  out  track/hold control, 1 = track
//   DAC     out  N-bit trial code
//   RESULT  out  N-bit code of the last completed conversion
//   DONE    out  one-cycle completion pulse
//   BUSY    out  high from START acceptance until completion or abort

module sar_ctrl #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic         C,
  input  logic         RN,
  input  logic         START,
  input  logic         ABORT,
  input  logic         CMP,
  output logic         SAMPLE,
  output logic [N-1:0] DAC,
  output logic [N-1:0] RESULT,
  output logic         DONE,
  output logic         BUSY
);

  // The sample counter only has to reach SAMPLE_CYCLES-1.
  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int IDX_W = $clog2(N);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(N - 1);
  localparam logic [N-1:0]     DAC_MSB  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_CONVERT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sample_q, sample_d;
  logic [N-1:0]     dac_q, dac_d;
  logic [N-1:0]     result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             cnt_last;
  logic             idx_zero;
  logic [N-1:0]     trial;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign idx_zero = (idx_q == '0);

  // One binary-search step: resolve the bit under test from CMP and, unless it
  // was the LSB, raise the next lower bit as the new trial.
  always_comb begin
    trial = dac_q;
    if (!CMP) begin
      trial[idx_q] = 1'b0;
    end
    if (!idx_zero) begin
      trial[idx_q - IDX_W'(1)] = 1'b1;
    end
  end

  // State register together with the registered outputs and datapath.
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q  <= S_IDLE;
      sample_q <= 1'b0;
      dac_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (cnt_last) begin
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (ABORT || idx_zero) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and datapath. DONE defaults low so
  // it can only ever be a single-cycle pulse.
  always_comb begin
    sample_d = sample_q;
    dac_d    = dac_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          sample_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      S_TRACK: begin
        if (ABORT) begin
          sample_d = 1'b0;
          dac_d    = '0;
          busy_d   = 1'b0;
        end else if (cnt_last) begin
          sample_d = 1'b0;
          dac_d    = DAC_MSB;
          idx_d    = IDX_MSB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CONVERT: begin
        if (ABORT) begin
          dac_d  = '0;
          busy_d = 1'b0;
        end else begin
          dac_d = trial;
          if (idx_zero) begin
            // LSB resolved: trial now holds the finished code.
            result_d = trial;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: begin
        sample_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign SAMPLE = sample_q;
  assign DAC    = dac_q;
  assign RESULT = result_q;
  assign DONE   = done_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// tb/tb_sar_ctrl.sv - scoreboard bench for sar_ctrl (N=4, SAMPLE_CYCLES=2)

module tb_sar_ctrl;

  localparam int LAT = 6;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] edge_no;
  } sb_entry_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       cmp;
  logic       sample;
  logic [3:0] dac;
  logic [3:0] result;
  logic       done;
  logic       busy;
  logic [3:0] vin_code;

  int          checks;
  int          errors;
  logic [31:0] edge_cnt;
  sb_entry_t   sb_q[$];

  sar_ctrl #(
    .N            (4),
    .SAMPLE_CYCLES(2)
  ) dut (
    .C      (clk),
    .RN     (rst_n),
    .START  (start),
    .ABORT  (abort),
    .CMP    (cmp),
    .SAMPLE (sample),
    .DAC    (dac),
    .RESULT (result),
    .DONE   (done),
    .BUSY   (busy)
  );

  // Ideal comparator.
  assign cmp = (vin_code >= dac);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic expect_done(input logic [3:0] code, input logic [31:0] at_edge);
    sb_entry_t e;
    e.code    = code;
    e.edge_no = at_edge;
    sb_q.push_back(e);
  endtask

  // Monitor: every DONE pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE at edge %0d expected none", edge_cnt);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check("done_result", 32'(result), 32'(e.code));
        check("done_edge", edge_cnt, e.edge_no);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish by 100000 expected earlier finish");
    $fatal(1);
  end

  // Full conversion from idle, checking the track window and every DAC trial.
  task automatic run_conv(input logic [3:0] vin, input logic [15:0] trials, input logic [3:0] exp);
    vin_code = vin;
    start    = 1'b1;
    expect_done(exp, edge_cnt + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    check("track_sample_e0", 32'(sample), 1);
    check("track_busy_e0", 32'(busy), 1);
    @(negedge clk);
    check("track_sample_e1", 32'(sample), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dac_trial", 32'(dac), 32'(trials[15-4*i -: 4]));
      if (i == 0) check("sample_low_e2", 32'(sample), 0);
    end
    @(negedge clk);
    check("end_busy", 32'(busy), 0);
    check("end_dac", 32'(dac), 32'(exp));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    vin_code = 4'd0;

    repeat (2) @(negedge clk);
    check("rst_sample", 32'(sample), 0);
    check("rst_dac", 32'(dac), 0);
    check("rst_result", 32'(result), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and extreme conversions.
    run_conv(4'd11, 16'h8CAB, 4'b1011);
    run_conv(4'd0,  16'h8421, 4'b0000);
    run_conv(4'd15, 16'h8CEF, 4'b1111);

    // Back-to-back with START held: 5 then 9, DONE pulses 7 edges apart.
    vin_code = 4'd5;
    start    = 1'b1;
    expect_done(4'b0101, edge_cnt + 1 + LAT);
    expect_done(4'b1001, edge_cnt + 1 + LAT + 7);
    repeat (LAT + 1) @(negedge clk);
    check("b2b_first_done", 32'(done), 1);
    check("b2b_first_sample", 32'(sample), 0);
    vin_code = 4'd9;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_fall", 32'(done), 0);
    check("b2b_sample_rise", 32'(sample), 1);
    check("b2b_busy", 32'(busy), 1);
    check("b2b_result_hold", 32'(result), 32'h5);
    repeat (LAT + 1) @(negedge clk);
    check("b2b_second_result", 32'(result), 32'h9);

    // START pulses during BUSY (sampled at e3 and e4) must be ignored.
    vin_code = 4'd11;
    start    = 1'b1;
    expect_done(4'b1011, edge_cnt + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_start_idle", 32'(busy), 0);
    check("busy_start_sample", 32'(sample), 0);

    // Abort during CONVERT with RESULT=0101 beforehand.
    run_conv(4'd5, 16'h8465, 4'b0101);
    vin_code = 4'd12;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_dac", 32'(dac), 0);
    check("abort_sample", 32'(sample), 0);
    check("abort_done", 32'(done), 0);
    check("abort_result", 32'(result), 32'h5);
    // ABORT beats START in IDLE.
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    check("abort_start_sample", 32'(sample), 0);
    @(negedge clk);
    check("abort_start_still_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of CONVERT.
    vin_code = 4'd11;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sample", 32'(sample), 0);
    check("arst_dac", 32'(dac), 0);
    check("arst_result", 32'(result), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_conv(4'd11, 16'h8CAB, 4'b1011);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
- Successive-approximation controller for LTspice mixed-signal testbenches.
- Sequences an external track/hold switch, an N-bit capacitive or resistive DAC and a single comparator to produce one N-bit conversion per START request.
- Built to map onto the synthesizable digital cell set (gates plus DFF variants) for transistor-level co-simulation.

Parameters:
- N, 8, conversion resolution in bits (N ≥ 2).
- SAMPLE_CYCLES, 2, number of clock cycles SAMPLE is held high (≥ 1).

Ports:
- C  input  1  clock; all state updates on rising edge.
- RN  input  1  asynchronous active-low reset.
- START  input  1  conversion request, sampled on rising C while idle.
- ABORT  input  1  synchronous abort of a running conversion.
- CMP  input  1  comparator output: 1 when analog input ≥ DAC voltage.
- SAMPLE  output  1  track/hold control: 1 = track.
- DAC  output  N  trial code driving the DAC.
- RESULT  output  N  last completed conversion code.
- DONE  output  1  one-cycle pulse on conversion completion.
- BUSY  output  1  high from START acceptance until completion or abort.

Behaviour:
- Reset (RN=0, asynchronous):
  - State IDLE.
  - SAMPLE=0, DAC=0, RESULT=0, DONE=0, BUSY=0.
  - Sample counter and bit index cleared.
  - Release is synchronous to the next rising C.
- States: IDLE, TRACK, CONVERT. All outputs are registered.
- IDLE:
  - DONE is cleared on every edge spent in IDLE.
  - If START=1 and ABORT=0 at edge e0: go to TRACK, SAMPLE=1, BUSY=1, sample counter=0.
  - Otherwise stay in IDLE; DAC and RESULT hold their values.
- TRACK:
  - Counter increments each edge.
  - At edge e(SAMPLE_CYCLES): SAMPLE=0, DAC = 1 shifted left by N-1 (MSB trial), bit index = N-1, go to CONVERT.
  - SAMPLE is therefore high for exactly SAMPLE_CYCLES clock periods.
- CONVERT: each edge resolves the bit at the current index using CMP as sampled on that edge.
  - CMP=1: keep the bit. CMP=0: clear the bit.
  - If index > 0: also set bit index-1 of DAC, then decrement the index.
  - If index = 0, at edge e(SAMPLE_CYCLES+N):
    - RESULT = final code; DAC holds the final code.
    - DONE=1, BUSY=0, go to IDLE.
- Latency: DONE rises SAMPLE_CYCLES+N edges after the edge that accepted START.
- Back-to-back operation: with START held high, a new conversion is accepted on the edge after DONE. DONE falls and SAMPLE rises on that same edge. Max throughput is one result per SAMPLE_CYCLES+N+1 cycles.
- START while BUSY=1: ignored. It is not queued.
- ABORT=1 in TRACK or CONVERT:
  - Next edge: go to IDLE, SAMPLE=0, DAC=0, BUSY=0, DONE stays 0.
  - RESULT keeps its previous value.
- ABORT in IDLE: no effect. ABORT has priority over START on the same edge.
- RN asserted mid-conversion: immediate return to reset values. No DONE is issued.
- CMP is used only in CONVERT; its value is ignored elsewhere.

Test Plan (N=4, SAMPLE_CYCLES=2, comparator model CMP = (vin_code ≥ DAC)):
- Basic conversion: vin_code=11, START pulse at e0.
  - SAMPLE high after e0 and e1, low after e2.
  - DAC sequence after e2..e5: 1000, 1100, 1010, 1011.
  - At e6: RESULT=1011, DONE=1 for one cycle, BUSY=0.
- Extremes:
  - vin_code=0 → DAC trials 1000, 0100, 0010, 0001; RESULT=0000.
  - vin_code=15 → RESULT=1111. DONE latency = 6 edges in both cases.
- Back-to-back: START held high, vin_code=5 then 9.
  - Two DONE pulses 7 cycles apart.
  - RESULT=0101, then 1001.
  - SAMPLE rises on the same edge DONE falls.
- START during BUSY: extra START pulses at e3 and e4 → ignored; exactly one DONE at e6.
- ABORT at e4 (during CONVERT), previous RESULT=0101:
  - At e5: BUSY=0, DAC=0000, SAMPLE=0, no DONE, RESULT still 0101.
  - ABORT and START both high in IDLE → stays IDLE.
- Async reset: RN pulled low between edges during CONVERT.
  - All outputs zero immediately, without a clock edge.
  - After RN release, a new START completes a normal conversion.
